// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param : parametrised synchronous FIFO
//
// Purpose
//   Single-clock FIFO of any depth (ENTRIES >= 2, not necessarily a power of
//   two). It reports its occupancy and threshold flags. It keeps sticky
//   overflow/underflow error flags and has a synchronous flush. The read port
//   works in one of two modes: show-ahead (REG_OUT=0) or registered
//   (REG_OUT=1).
//
// Ports
//   clk           in   1     clock, all logic on the rising edge
//   rst           in   1     synchronous reset, active-low
//   clr           in   1     synchronous flush, active-high
//   push          in   1     write request
//   datain        in   BUSW  write data
//   pull          in   1     read request
//   dataout       out  BUSW  read data
//   rd_valid      out  1     REG_OUT=1: dataout holds a word popped last cycle
//   empty         out  1     level == 0
//   full          out  1     level == ENTRIES
//   almost_empty  out  1     level <= AE_THRESH
//   almost_full   out  1     level >= AF_THRESH
//   level         out  LW    occupancy, 0..ENTRIES
//   overflow      out  1     sticky: push attempted while full
//   underflow     out  1     sticky: pull attempted while empty
//
// Handshake: push and pull are requests that the FIFO accepts or refuses.
//   Acceptance uses only the registered state of the FIFO.
//   - A push is accepted when push && !full.
//   - A pull is accepted when pull && !empty.
//   A refused request is dropped and sets its sticky error flag. This also
//   holds when the opposite request is accepted in the same cycle, so a full
//   FIFO never passes a word through. In show-ahead mode, dataout is the head
//   word whenever !empty, and the edge of an accepted pull consumes it.
// -----------------------------------------------------------------------------
module fifo_param #(
    parameter  int BUSW      = 32,
    parameter  int ENTRIES   = 32,
    parameter  int AF_THRESH = 28,
    parameter  int AE_THRESH = 4,
    parameter  int REG_OUT   = 0,
    localparam int LW        = $clog2(ENTRIES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic [BUSW-1:0] datain,
    input  logic            pull,
    output logic [BUSW-1:0] dataout,
    output logic            rd_valid,
    output logic            empty,
    output logic            full,
    output logic            almost_empty,
    output logic            almost_full,
    output logic [LW-1:0]   level,
    output logic            overflow,
    output logic            underflow
);

    localparam int PW = $clog2(ENTRIES);

    logic [BUSW-1:0] mem [ENTRIES];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            push_acc;
    logic            pull_acc;

    // Explicit wrap compare so that non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push_acc = push && !full;
    assign pull_acc = pull && !empty;

    // Status flags are decoded from the registered level.
    assign empty        = (level == '0);
    assign full         = (level == LW'(ENTRIES));
    assign almost_empty = (level <= LW'(AE_THRESH));
    assign almost_full  = (level >= LW'(AF_THRESH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            head      <= '0;
            tail      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) head <= next_ptr(head);
            if (pull_acc) tail <= next_ptr(tail);
            case ({push_acc, pull_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && full)  overflow  <= 1'b1;
            if (pull && empty) underflow <= 1'b1;
        end
    end

    // Storage has no reset. Writes are blocked during reset and flush.
    always_ff @(posedge clk) begin
        if (rst && !clr && push_acc) mem[head] <= datain;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dataout  <= '0;
                    rd_valid <= 1'b0;
                end else if (clr) begin
                    rd_valid <= 1'b0;
                end else if (pull_acc) begin
                    dataout  <= mem[tail];
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end else begin : g_show_ahead
            assign dataout  = mem[tail];
            assign rd_valid = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_param : bench for fifo_param
//   Two instances (show-ahead and registered read, ENTRIES=5, AF=4, AE=1)
//   share one stimulus stream. A queue-based model is compared against both
//   instances on every falling edge. Directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_fifo_param;

    localparam int W  = 16;
    localparam int E  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int LW = $clog2(E + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         push = 1'b0;
    logic         pull = 1'b0;
    logic [W-1:0] datain = '0;

    logic [W-1:0]  dout_s, dout_r;
    logic          rv_s, rv_r;
    logic          emp_s, emp_r, ful_s, ful_r, ae_s, ae_r, af_s, af_r;
    logic [LW-1:0] lvl_s, lvl_r;
    logic          ovf_s, ovf_r, unf_s, unf_r;

    fifo_param #(.BUSW(W), .ENTRIES(E), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(0)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .datain(datain), .pull(pull),
        .dataout(dout_s), .rd_valid(rv_s), .empty(emp_s), .full(ful_s),
        .almost_empty(ae_s), .almost_full(af_s), .level(lvl_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    fifo_param #(.BUSW(W), .ENTRIES(E), .AF_THRESH(AF), .AE_THRESH(AE), .REG_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .datain(datain), .pull(pull),
        .dataout(dout_r), .rd_valid(rv_r), .empty(emp_r), .full(ful_r),
        .almost_empty(ae_r), .almost_full(af_r), .level(lvl_r),
        .overflow(ovf_r), .underflow(unf_r)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] exp_q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic         m_rv  = 1'b0;
    logic [W-1:0] m_rdata = '0;
    logic         model_ok = 1'b0;

    always @(posedge clk) begin
        bit did_push, did_pull;
        if (!rst) begin
            exp_q.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = '0;
            model_ok = 1'b1;
        end else if (clr) begin
            exp_q.delete();
            m_ovf = 0; m_unf = 0; m_rv = 0;
        end else begin
            did_push = push && (exp_q.size() < E);
            did_pull = pull && (exp_q.size() > 0);
            if (push && exp_q.size() == E) m_ovf = 1;
            if (pull && exp_q.size() == 0) m_unf = 1;
            if (did_pull) begin
                m_rdata = exp_q.pop_front();
                m_rv = 1;
            end else begin
                m_rv = 0;
            end
            if (did_push) exp_q.push_back(datain);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            int n;
            n = exp_q.size();
            check("level_s",  32'(lvl_s), 32'(n));
            check("level_r",  32'(lvl_r), 32'(n));
            check("empty",    32'(emp_s), 32'(n == 0));
            check("full",     32'(ful_s), 32'(n == E));
            check("a_empty",  32'(ae_s),  32'(n <= AE));
            check("a_full",   32'(af_s),  32'(n >= AF));
            check("full_r",   32'(ful_r), 32'(n == E));
            check("a_empty_r",32'(ae_r),  32'(n <= AE));
            check("overflow", 32'(ovf_s), 32'(m_ovf));
            check("underflow",32'(unf_s), 32'(m_unf));
            check("ovf_r",    32'(ovf_r), 32'(m_ovf));
            check("unf_r",    32'(unf_r), 32'(m_unf));
            check("rd_valid_s", 32'(rv_s), 32'(0));
            if (n > 0) check("dout_s", 32'(dout_s), 32'(exp_q[0]));
            check("rd_valid_r", 32'(rv_r), 32'(m_rv));
            check("dout_r",   32'(dout_r), 32'(m_rdata));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic c, input logic p,
                        input logic [W-1:0] d, input logic pl);
        rst = r; clr = c; push = p; datain = d; pull = pl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [W-1:0] d); step(1, 0, 1, d, 0);  endtask
    task automatic do_pull();                      step(1, 0, 0, '0, 1); endtask
    task automatic do_idle();                      step(1, 0, 0, '0, 0); endtask
    task automatic do_both(input logic [W-1:0] d); step(1, 0, 1, d, 1);  endtask

    // ---------------- directed sequence ----------------
    initial begin
        // 1: reset held two cycles with push asserted
        step(0, 0, 1, 16'h1111, 0);
        step(0, 0, 1, 16'h2222, 0);
        check("t1_level", 32'(lvl_s), 0);
        check("t1_empty", 32'(emp_s), 1);
        check("t1_ae",    32'(ae_s),  1);
        check("t1_ovf",   32'(ovf_s), 0);
        check("t1_dout_r",32'(dout_r), 0);
        do_idle();
        check("t1_no_write", 32'(lvl_s), 0);

        // 2: fill and drain
        for (int i = 0; i < 5; i++) begin
            do_push(16'hA000 + 16'(i));
            check("t2_fill_level", 32'(lvl_s), 32'(i + 1));
            check("t2_fill_af",    32'(af_s),  32'(i + 1 >= 4));
            check("t2_fill_full",  32'(ful_s), 32'(i == 4));
        end
        for (int i = 0; i < 5; i++) begin
            check("t2_show_ahead", 32'(dout_s), 32'(16'hA000 + 16'(i)));
            do_pull();
            check("t2_reg_dout", 32'(dout_r), 32'(16'hA000 + 16'(i)));
            check("t2_reg_valid", 32'(rv_r), 1);
            check("t2_drain_level", 32'(lvl_s), 32'(4 - i));
        end
        check("t2_empty", 32'(emp_s), 1);

        // 3: wrap
        for (int i = 0; i < 3; i++) do_push(16'hB000 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            do_pull();
            check("t3_b_order", 32'(dout_r), 32'(16'hB000 + 16'(i)));
        end
        for (int i = 0; i < 5; i++) begin
            do_push(16'hC000 + 16'(i));
            check("t3_level", 32'(lvl_s), 32'(i + 1));
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_c_show", 32'(dout_s), 32'(16'hC000 + 16'(i)));
            do_pull();
            check("t3_c_order", 32'(dout_r), 32'(16'hC000 + 16'(i)));
        end

        // 4: simultaneous push and pull
        do_push(16'hD000);
        do_push(16'hD001);
        for (int i = 0; i < 10; i++) begin
            do_both(16'hD002 + 16'(i));
            check("t4_level", 32'(lvl_s), 2);
            check("t4_order", 32'(dout_r), 32'(16'hD000 + 16'(i)));
        end
        for (int i = 0; i < 3; i++) do_push(16'hE000 + 16'(i));
        check("t4_full", 32'(ful_s), 1);
        do_both(16'hEEEE);
        check("t4_full_both_level", 32'(lvl_s), 4);
        check("t4_full_both_ovf",   32'(ovf_s), 1);
        check("t4_full_both_dout",  32'(dout_r), 32'(16'hD00A));
        check("t4_after_show", 32'(dout_s), 32'(16'hD00B));
        for (int i = 0; i < 4; i++) do_pull();
        check("t4_last_word", 32'(dout_r), 32'(16'hE002));

        // 5: underflow and flush
        do_pull();
        check("t5_unf", 32'(unf_s), 1);
        check("t5_unf_rv", 32'(rv_r), 0);
        for (int i = 0; i < 3; i++) begin
            do_idle();
            check("t5_unf_sticky", 32'(unf_s), 1);
        end
        step(1, 1, 1, 16'h5555, 0);
        check("t5_clr_level", 32'(lvl_s), 0);
        check("t5_clr_unf",   32'(unf_s), 0);
        check("t5_clr_ovf",   32'(ovf_s), 0);
        do_idle();
        check("t5_dropped", 32'(lvl_s), 0);

        // 6: registered read
        do_push(16'hDEAD);
        do_pull();
        check("t6_rv",   32'(rv_r),   1);
        check("t6_dout", 32'(dout_r), 32'(16'hDEAD));
        do_idle();
        check("t6_rv_idle",   32'(rv_r),   0);
        check("t6_dout_hold", 32'(dout_r), 32'(16'hDEAD));

        // random traffic, checked by the model
        for (int i = 0; i < 400; i++) begin
            step(1, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        do_idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
